// File: rtl/keypad_event_fifo_if.sv
// Bus-side port of keypad_event_fifo: key-code valid/ready handshake plus overflow status.
// The master is the FIFO; the slave is the register block reading key codes.
interface keypad_event_fifo_if #(
  parameter int AW = 3
);
  logic          evt_valid;
  logic [3:0]    evt_code;
  logic          evt_ready;
  logic [AW:0]   evt_count;
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output evt_valid, evt_code, evt_count, ovf,
    input  evt_ready, ovf_clr
  );

  modport slave (
    input  evt_valid, evt_code, evt_count, ovf,
    output evt_ready, ovf_clr
  );
endinterface

// File: rtl/keypad_event_fifo.sv
// Turns keypad row results (active-low new-press masks) into {row, col} key codes,
// one per cycle in ascending column order, and queues them for the bus-side reader.
module keypad_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 row_rdy,
  input  logic [1:0]           hi,
  input  logic [3:0]           col_out,
  keypad_event_fifo_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic            row_rdy_q, row_rdy_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      row_q, row_d;
  logic            pend_vld_q, pend_vld_d;
  logic [3:0]      pend_mask_q, pend_mask_d;
  logic [1:0]      pend_row_q, pend_row_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            evt_valid_q, evt_valid_d;
  logic [3:0]      evt_code_q, evt_code_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      mem_q [DEPTH];

  logic [3:0]      cap_mask_s;
  logic            cap_s;
  logic [3:0]      mask_left_s;
  logic            push_s;
  logic [3:0]      push_code_s;
  logic            drop_s;
  logic            full_s;
  logic            pop_s;
  logic            push_en_s;
  logic            ovf_set_s;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0]) begin
      return 2'd0;
    end else if (m[1]) begin
      return 2'd1;
    end else if (m[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  // Capture decode and IDLE/EMIT next-state, including the one-entry pending slot.
  always_comb begin
    row_rdy_d   = row_rdy;
    cap_mask_s  = ~col_out;
    cap_s       = row_rdy_q && (cap_mask_s != 4'h0);
    state_d     = state_q;
    mask_d      = mask_q;
    row_d       = row_q;
    pend_vld_d  = pend_vld_q;
    pend_mask_d = pend_mask_q;
    pend_row_d  = pend_row_q;
    push_s      = 1'b0;
    push_code_s = {row_q, lowest_bit(mask_q)};
    mask_left_s = mask_q & (mask_q - 4'd1);
    drop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_s) begin
          mask_d  = cap_mask_s;
          row_d   = hi;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        push_s = 1'b1;
        mask_d = mask_left_s;
        if (mask_left_s == 4'h0) begin
          // The pending slot frees up this cycle, so a coincident capture can take it.
          if (pend_vld_q) begin
            mask_d      = pend_mask_q;
            row_d       = pend_row_q;
            pend_vld_d  = cap_s;
            pend_mask_d = cap_mask_s;
            pend_row_d  = hi;
          end else if (cap_s) begin
            mask_d = cap_mask_s;
            row_d  = hi;
          end else begin
            state_d = IDLE;
          end
        end else if (cap_s) begin
          if (pend_vld_q) begin
            drop_s = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_mask_d = cap_mask_s;
            pend_row_d  = hi;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy, registered head code and sticky overflow.
  always_comb begin
    full_s    = (count_q == DEPTH_C);
    pop_s     = evt_valid_q && bus.evt_ready;
    push_en_s = push_s && (!full_s || pop_s);
    ovf_set_s = drop_s || (push_s && full_s && !pop_s);
    wr_ptr_d  = push_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_en_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    evt_valid_d = (count_d != (AW+1)'(0));
    // When the new read pointer lands on the slot being written, the head is the incoming code.
    if (!evt_valid_d) begin
      evt_code_d = 4'h0;
    end else if (push_en_s && (wr_ptr_q == rd_ptr_d)) begin
      evt_code_d = push_code_s;
    end else begin
      evt_code_d = mem_q[rd_ptr_d];
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_rdy_q   <= 1'b0;
      mask_q      <= 4'h0;
      row_q       <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_mask_q <= 4'h0;
      pend_row_q  <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 4'h0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_rdy_q   <= row_rdy_d;
      mask_q      <= mask_d;
      row_q       <= row_d;
      pend_vld_q  <= pend_vld_d;
      pend_mask_q <= pend_mask_d;
      pend_row_q  <= pend_row_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_q[wr_ptr_q] <= push_code_s;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_count = count_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: directed vector table, hand-written corner sequences,
// then random traffic, all scored against a queue-based model of the key-event stream.
module tb_keypad_event_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       row_rdy;
  logic [1:0] hi;
  logic [3:0] col_out;
  logic       evt_ready;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  keypad_event_fifo_if #(.AW(AW)) bus ();
  assign bus.evt_ready = evt_ready;
  assign bus.ovf_clr   = ovf_clr;

  keypad_event_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_rdy (row_rdy),
    .hi      (hi),
    .col_out (col_out),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: codes still to emit for the current row, one queued row, output queue.
  logic [3:0] fifo_m[$];
  logic [3:0] cur_m[$];
  logic [3:0] pend_m[$];
  bit         rdy_seen_m;
  bit         ovf_m;

  task automatic model_update();
    logic [3:0] capq[$];
    logic [3:0] pcode;
    bit         ovf_set;
    bit         has_push;
    if (rst) begin
      fifo_m = {};
      cur_m = {};
      pend_m = {};
      rdy_seen_m = 1'b0;
      ovf_m = 1'b0;
      return;
    end
    capq = {};
    if (rdy_seen_m) begin
      for (int i = 0; i < 4; i++) begin
        if (!col_out[i]) capq.push_back({hi, 2'(i)});
      end
    end
    ovf_set = 1'b0;
    has_push = 1'b0;
    pcode = 4'h0;
    if (cur_m.size() > 0) begin
      pcode = cur_m.pop_front();
      has_push = 1'b1;
      if (cur_m.size() == 0) begin
        if (pend_m.size() > 0) begin
          cur_m = pend_m;
          pend_m = capq;
        end else begin
          cur_m = capq;
        end
      end else if (capq.size() > 0) begin
        if (pend_m.size() > 0) ovf_set = 1'b1;
        else pend_m = capq;
      end
    end else begin
      cur_m = capq;
    end
    if (fifo_m.size() > 0 && evt_ready) void'(fifo_m.pop_front());
    if (has_push) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(pcode);
      else ovf_set = 1'b1;
    end
    if (ovf_set) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    rdy_seen_m = row_rdy;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("m_valid", 8'(bus.evt_valid), 8'(fifo_m.size() != 0));
    chk("m_code",  8'(bus.evt_code),  (fifo_m.size() != 0) ? 8'(fifo_m[0]) : 8'h00);
    chk("m_count", 8'(bus.evt_count), 8'(fifo_m.size()));
    chk("m_ovf",   8'(bus.ovf),       8'(ovf_m));
  endtask

  task automatic drive(input logic r, input logic [1:0] h, input logic [3:0] c,
                       input logic rd, input logic clr);
    row_rdy = r; hi = h; col_out = c; evt_ready = rd; ovf_clr = clr;
  endtask

  // Strobe then hold the row data for the sampling cycle, with the reader stalled.
  task automatic capture(input logic [1:0] h, input logic [3:0] c);
    drive(1'b1, h, c, 1'b0, 1'b0); step();
    drive(1'b0, h, c, 1'b0, 1'b0); step();
    drive(1'b0, 2'd0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic       row_rdy;
    logic [1:0] hi;
    logic [3:0] col_out;
    logic       evt_ready;
    logic       exp_valid;
    logic [3:0] exp_code;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 4'b1101, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[1]  = '{1'b0, 2'd2, 4'b1101, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[2]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 1'b1, 4'h9, 4'd1};
    vecs[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 4'h0, 4'd0};
    vecs[4]  = '{1'b1, 2'd3, 4'b0110, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[5]  = '{1'b0, 2'd3, 4'b0110, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[6]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 1'b1, 4'hC, 4'd1};
    vecs[7]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 1'b1, 4'hC, 4'd2};
    vecs[8]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 1'b1, 4'hF, 4'd1};
    vecs[9]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 4'h0, 4'd0};
    vecs[10] = '{1'b1, 2'd1, 4'b1111, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[11] = '{1'b0, 2'd1, 4'b1111, 1'b0, 1'b0, 4'h0, 4'd0};
    vecs[12] = '{1'b0, 2'd1, 4'b1111, 1'b0, 1'b0, 4'h0, 4'd0};

    rst = 1'b1;
    drive(1'b0, 2'd0, 4'hF, 1'b0, 1'b0);
    step();
    step();
    chk("rst_valid", 8'(bus.evt_valid), 8'h00);
    chk("rst_code",  8'(bus.evt_code),  8'h00);
    chk("rst_count", 8'(bus.evt_count), 8'h00);
    chk("rst_ovf",   8'(bus.ovf),       8'h00);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].row_rdy, vecs[i].hi, vecs[i].col_out, vecs[i].evt_ready, 1'b0);
      step();
      chk($sformatf("vec%0d_valid", i), 8'(bus.evt_valid), 8'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_code", i),  8'(bus.evt_code),  8'(vecs[i].exp_code));
      chk($sformatf("vec%0d_count", i), 8'(bus.evt_count), 8'(vecs[i].exp_count));
    end

    // Back-to-back rows two cycles apart: second row goes through the pending slot.
    drive(1'b1, 2'd0, 4'b0000, 1'b0, 1'b0); step();
    drive(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0); step();
    drive(1'b1, 2'd1, 4'b1110, 1'b0, 1'b0); step();
    drive(1'b0, 2'd1, 4'b1110, 1'b0, 1'b0); step();
    drive(1'b0, 2'd0, 4'b1111, 1'b0, 1'b0);
    idle(5);
    chk("b2b_count", 8'(bus.evt_count), 8'd5);
    chk("b2b_ovf",   8'(bus.ovf),       8'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_code%0d", i), 8'(bus.evt_code), 8'(i));
      evt_ready = 1'b1; step(); evt_ready = 1'b0;
    end
    chk("b2b_empty", 8'(bus.evt_valid), 8'd0);

    // Nine codes into an eight-deep FIFO with the reader stalled.
    capture(2'd0, 4'b0000); idle(5);
    capture(2'd1, 4'b0000); idle(5);
    chk("full_count", 8'(bus.evt_count), 8'd8);
    chk("full_ovf0",  8'(bus.ovf),       8'd0);
    capture(2'd2, 4'b1110); idle(3);
    chk("ovf_count", 8'(bus.evt_count), 8'd8);
    chk("ovf_set",   8'(bus.ovf),       8'd1);
    chk("ovf_head",  8'(bus.evt_code),  8'h0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 8'(bus.ovf), 8'd0);
    capture(2'd3, 4'b1110);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    chk("pushpop_count", 8'(bus.evt_count), 8'd8);
    chk("pushpop_ovf",   8'(bus.ovf),       8'd0);
    chk("pushpop_head",  8'(bus.evt_code),  8'h1);

    // Reset in the middle of a four-code burst, then a normal row.
    capture(2'd0, 4'b0000);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rmid_valid", 8'(bus.evt_valid), 8'd0);
    chk("rmid_count", 8'(bus.evt_count), 8'd0);
    chk("rmid_ovf",   8'(bus.ovf),       8'd0);
    capture(2'd2, 4'b1011);
    step();
    chk("post_valid", 8'(bus.evt_valid), 8'd1);
    chk("post_code",  8'(bus.evt_code),  8'hA);
    chk("post_count", 8'(bus.evt_count), 8'd1);

    // Random traffic; the first half stalls the reader more so overflow gets exercised.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      row_rdy   = ($urandom_range(0, 2) == 0);
      hi        = 2'($urandom_range(0, 3));
      col_out   = 4'($urandom_range(0, 15));
      evt_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
